arb_mult_flotante: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 13-bit floating-point multiplier among `N_REQ` requesters. The float format is 1 sign, 4 exponent and 8 mantissa bits. The block accepts one operand pair at a time over valid/ready and registers the operands into the shared multiplier. It captures the product and returns it on a single tagged result channel with backpressure. It sits between the requesting datapaths and the existing multiplier top.

---
 rtl/arb_mult_flotante_pkg.sv | 26 ++
 rtl/arb_mult_flotante_rr_arbitro.sv | 43 ++++
 rtl/arb_mult_flotante.sv | 157 +++++++++++++++
 tb/tb_arb_mult_flotante.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mult_flotante_pkg.sv
// ---------------------------------------------------------------------------
// arb_mult_flotante_pkg
// Shared definitions for the round-robin multiplier arbiter.
//   - float format widths (1 sign, 4 exponent, 8 mantissa bits)
//   - FSM state encoding
//   - is_zero(): true when the magnitude bits [11:0] of a float are all zero
// No ports; imported by arb_mult_flotante and rr_arbitro.
// ---------------------------------------------------------------------------
package arb_mult_flotante_pkg;

    localparam int NB_FLOAT = 13;
    localparam int NB_EXP   = 4;
    localparam int NB_MANT  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // A float is zero regardless of sign when exponent and mantissa are zero.
    function automatic logic is_zero(input logic [NB_FLOAT-1:0] f);
        return (f[NB_FLOAT-2:0] == '0);
    endfunction

endpackage

// File: rtl/arb_mult_flotante_rr_arbitro.sv
// ---------------------------------------------------------------------------
// rr_arbitro
// Purely combinational round-robin arbiter. Picks the first active request
// searching cyclically from last_grant+1, wrapping after N_REQ-1 to 0.
// Ports:
//   req        in  N_REQ  request vector
//   last_grant in  NB_ID  index granted most recently
//   grant      out N_REQ  one-hot grant (all zero when no request)
//   grant_idx  out NB_ID  encoded grant index (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbitro
    import arb_mult_flotante_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int NB_ID = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [NB_ID-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [NB_ID-1:0] grant_idx
);

    // Walk offsets 1..N_REQ from the last winner; the first hit wins. The
    // offset N_REQ lands back on last_grant itself, so a lone requester that
    // just won can win again.
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_grant) + off) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = NB_ID'(idx);
            end
        end
    end

endmodule

// File: rtl/arb_mult_flotante.sv
// ---------------------------------------------------------------------------
// arb_mult_flotante
// Shares one external combinational 13-bit float multiplier among N_REQ
// requesters. One operand pair is accepted at a time (round robin), the
// operands are registered toward the multiplier, the product is captured
// and returned on a tagged result channel with backpressure.
//
// Optional feature macro: ARB_MULT_ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips the multiplier: the
//   result is a signed zero produced directly in IDLE and the FSM goes
//   straight to HOLD, leaving the multiplier operand registers untouched.
//
// Ports:
//   clock         in   rising-edge clock
//   i_reset_n     in   asynchronous active-low reset
//   i_req_valid   in   N_REQ request valids
//   o_req_ready   out  N_REQ one-hot accept strobe (IDLE only)
//   i_req_op_1/2  in   packed operands, requester k at [13k+12:13k]
//   o_mul_op_1/2  out  registered operands to the shared multiplier
//   i_mul_result  in   product from the shared multiplier
//   o_res_valid   out  result available (HOLD)
//   o_res_data    out  registered product
//   o_res_id      out  owner index of the result
//   i_res_ready   in   consumer accepts the result
//   o_busy        out  state is not IDLE
// ---------------------------------------------------------------------------
module arb_mult_flotante
    import arb_mult_flotante_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int NB_ID = 2
) (
    input  logic                      clock,
    input  logic                      i_reset_n,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*NB_FLOAT-1:0] i_req_op_1,
    input  logic [N_REQ*NB_FLOAT-1:0] i_req_op_2,
    output logic [NB_FLOAT-1:0]       o_mul_op_1,
    output logic [NB_FLOAT-1:0]       o_mul_op_2,
    input  logic [NB_FLOAT-1:0]       i_mul_result,
    output logic                      o_res_valid,
    output logic [NB_FLOAT-1:0]       o_res_data,
    output logic [NB_ID-1:0]          o_res_id,
    input  logic                      i_res_ready,
    output logic                      o_busy
);

    state_t                state;
    state_t                state_next;
    logic [NB_ID-1:0]      last_grant;
    logic [N_REQ-1:0]      grant;
    logic [NB_ID-1:0]      grant_idx;
    logic [NB_FLOAT-1:0]   sel_op_1;
    logic [NB_FLOAT-1:0]   sel_op_2;
    logic                  req_any;
    logic                  take_bypass;
    logic                  accept;

    rr_arbitro #(
        .N_REQ (N_REQ),
        .NB_ID (NB_ID)
    ) u_rr_arbitro (
        .req        (i_req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req_any = |i_req_valid;
    assign accept  = (state == IDLE) && req_any;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_op_1 = '0;
        sel_op_2 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_op_1 = i_req_op_1[k*NB_FLOAT +: NB_FLOAT];
                sel_op_2 = i_req_op_2[k*NB_FLOAT +: NB_FLOAT];
            end
        end
    end

`ifdef ARB_MULT_ZERO_BYPASS_EN
    assign take_bypass = is_zero(sel_op_1) || is_zero(sel_op_2);
`else
    assign take_bypass = 1'b0;
`endif

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is also held low while reset is asserted so every output reads 0
    // during reset even if requesters keep valid high.
    always_comb begin
        state_next  = state;
        o_req_ready = '0;
        o_res_valid = 1'b0;
        o_busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (i_reset_n) begin
                    o_req_ready = grant;
                end
                if (req_any) begin
                    state_next = take_bypass ? HOLD : ISSUE;
                end
            end
            ISSUE: begin
                state_next = HOLD;
            end
            HOLD: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. A bypassed request leaves the multiplier operands
    // alone and writes the signed zero straight into the result register.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_grant <= NB_ID'(N_REQ - 1);
            o_res_id   <= '0;
            o_mul_op_1 <= '0;
            o_mul_op_2 <= '0;
            o_res_data <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                o_res_id   <= grant_idx;
                if (take_bypass) begin
                    o_res_data <= {sel_op_1[NB_FLOAT-1] ^ sel_op_2[NB_FLOAT-1],
                                   {(NB_FLOAT-1){1'b0}}};
                end else begin
                    o_mul_op_1 <= sel_op_1;
                    o_mul_op_2 <= sel_op_2;
                end
            end
            if (state == ISSUE) begin
                o_res_data <= i_mul_result;
            end
        end
    end

endmodule

// File: tb/tb_arb_mult_flotante.sv
// ---------------------------------------------------------------------------
// tb_arb_mult_flotante
// Self-checking bench for arb_mult_flotante (N_REQ=2). The shared multiplier
// is stood in for by a simple scrambling function so each product is
// distinguishable. Honours ARB_MULT_ZERO_BYPASS_EN for the zero case.
// ---------------------------------------------------------------------------
module tb_arb_mult_flotante;

    localparam int N_REQ = 2;
    localparam int NB_ID = 2;

    logic              clock = 1'b0;
    logic              i_reset_n;
    logic [1:0]        i_req_valid;
    logic [1:0]        o_req_ready;
    logic [25:0]       i_req_op_1;
    logic [25:0]       i_req_op_2;
    logic [12:0]       o_mul_op_1;
    logic [12:0]       o_mul_op_2;
    logic [12:0]       i_mul_result;
    logic              o_res_valid;
    logic [12:0]       o_res_data;
    logic [NB_ID-1:0]  o_res_id;
    logic              i_res_ready;
    logic              o_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [12:0] a0;
        logic [12:0] b0;
        logic [12:0] a1;
        logic [12:0] b1;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[7];

    // Stand-in for the external multiplier: any fixed bijective-ish scramble.
    function automatic logic [12:0] mul_model(input logic [12:0] a, input logic [12:0] b);
        return a ^ (b + 13'h0101);
    endfunction

    assign i_mul_result = mul_model(o_mul_op_1, o_mul_op_2);

    always #5 clock = ~clock;

    arb_mult_flotante #(
        .N_REQ (N_REQ),
        .NB_ID (NB_ID)
    ) dut (
        .clock        (clock),
        .i_reset_n    (i_reset_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_op_1   (i_req_op_1),
        .i_req_op_2   (i_req_op_2),
        .o_mul_op_1   (o_mul_op_1),
        .o_mul_op_2   (o_mul_op_2),
        .i_mul_result (i_mul_result),
        .o_res_valid  (o_res_valid),
        .o_res_data   (o_res_data),
        .o_res_id     (o_res_id),
        .i_res_ready  (i_res_ready),
        .o_busy       (o_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [12:0] a0, input logic [12:0] b0,
                                 input logic [12:0] a1, input logic [12:0] b1,
                                 input logic rdy);
        i_req_valid = valid;
        i_req_op_1  = {a1, a0};
        i_req_op_2  = {b1, b0};
        i_res_ready = rdy;
    endtask

    task automatic nextDrive();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        i_reset_n = 1'b0;
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        nextDrive();
        nextDrive();
        i_reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  oh;
        logic [12:0] ea;
        logic [12:0] eb;
        logic [12:0] keep_data;

        vecs[0] = '{2'b01, 13'h15C6, 13'h0C1D, 13'h0123, 13'h0456, 2'd0};
        vecs[1] = '{2'b11, 13'h0A0A, 13'h0B0B, 13'h1111, 13'h0222, 2'd1};
        vecs[2] = '{2'b11, 13'h0333, 13'h1444, 13'h0555, 13'h0666, 2'd0};
        vecs[3] = '{2'b01, 13'h0777, 13'h0888, 13'h0999, 13'h0AAA, 2'd0};
        vecs[4] = '{2'b10, 13'h0BBB, 13'h0CCC, 13'h0DDD, 13'h0EEE, 2'd1};
        vecs[5] = '{2'b10, 13'h0F0F, 13'h10F0, 13'h1ABC, 13'h0DEF, 2'd1};
        vecs[6] = '{2'b11, 13'h1357, 13'h0246, 13'h1FFF, 13'h1FFF, 2'd0};

        // Reset state, with both requesters already asserting valid.
        i_reset_n = 1'b0;
        applyStimulus(2'b11, 13'h0111, 13'h0222, 13'h0333, 13'h0444, 1'b0);
        @(negedge clock);
        checkOutput("rst_busy",   o_busy,      0);
        checkOutput("rst_valid",  o_res_valid, 0);
        checkOutput("rst_data",   o_res_data,  0);
        checkOutput("rst_id",     o_res_id,    0);
        checkOutput("rst_mulop1", o_mul_op_1,  0);
        checkOutput("rst_mulop2", o_mul_op_2,  0);
        checkOutput("rst_ready",  o_req_ready, 0);
        nextDrive();
        i_reset_n = 1'b1;

        // Table-driven single transactions, i_res_ready held high.
        for (int v = 0; v < 7; v++) begin
            oh = (vecs[v].exp_id == 2'd0) ? 2'b01 : 2'b10;
            ea = (vecs[v].exp_id == 2'd0) ? vecs[v].a0 : vecs[v].a1;
            eb = (vecs[v].exp_id == 2'd0) ? vecs[v].b0 : vecs[v].b1;
            applyStimulus(vecs[v].valid, vecs[v].a0, vecs[v].b0, vecs[v].a1, vecs[v].b1, 1'b1);
            @(negedge clock);
            checkOutput("tbl_ready", o_req_ready, oh);
            nextDrive();
            applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
            @(negedge clock);
            checkOutput("tbl_issue_busy",  o_busy, 1);
            checkOutput("tbl_issue_valid", o_res_valid, 0);
            checkOutput("tbl_mulop1", o_mul_op_1, ea);
            checkOutput("tbl_mulop2", o_mul_op_2, eb);
            nextDrive();
            @(negedge clock);
            checkOutput("tbl_hold_valid", o_res_valid, 1);
            checkOutput("tbl_data", o_res_data, mul_model(ea, eb));
            checkOutput("tbl_id", o_res_id, vecs[v].exp_id);
            if (v == 0) checkOutput("single_data_const", o_res_data, 13'h18D8);
            nextDrive();
            @(negedge clock);
            checkOutput("tbl_idle_busy", o_busy, 0);
            nextDrive();
        end

        // Contention: both valid continuously, grants alternate every 3 cycles.
        doReset();
        applyStimulus(2'b11, 13'h0421, 13'h0135, 13'h1246, 13'h0357, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (c % 3 == 0) oh = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            else            oh = 2'b00;
            checkOutput("cont_ready", o_req_ready, oh);
            checkOutput("cont_valid", o_res_valid, (c % 3 == 2));
            if (c % 3 == 2) begin
                checkOutput("cont_id", o_res_id, (c / 3) % 2);
                if ((c / 3) % 2 == 0) checkOutput("cont_data", o_res_data, mul_model(13'h0421, 13'h0135));
                else                  checkOutput("cont_data", o_res_data, mul_model(13'h1246, 13'h0357));
            end
            nextDrive();
        end
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        nextDrive();

        // Backpressure: HOLD for 5 cycles with both requesters still asking.
        doReset();
        applyStimulus(2'b01, 13'h0A55, 13'h0333, 13'h0666, 13'h0777, 1'b0);
        @(negedge clock);
        checkOutput("bp_ready", o_req_ready, 2'b01);
        nextDrive();
        applyStimulus(2'b11, 13'h0A55, 13'h0333, 13'h0666, 13'h0777, 1'b0);
        nextDrive();
        keep_data = mul_model(13'h0A55, 13'h0333);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checkOutput("bp_valid", o_res_valid, 1);
            checkOutput("bp_data",  o_res_data,  keep_data);
            checkOutput("bp_id",    o_res_id,    0);
            checkOutput("bp_noacc", o_req_ready, 0);
            nextDrive();
        end
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        @(negedge clock);
        checkOutput("bp_release_valid", o_res_valid, 1);
        nextDrive();
        @(negedge clock);
        checkOutput("bp_idle_busy",  o_busy, 0);
        checkOutput("bp_idle_valid", o_res_valid, 0);
        nextDrive();

        // Reset while in ISSUE; last_grant=0 beforehand, so req0 winning
        // afterward proves the pointer was reset too.
        doReset();
        applyStimulus(2'b01, 13'h0A55, 13'h0333, 13'h0666, 13'h0777, 1'b1);
        nextDrive();
        applyStimulus(2'b11, 13'h0A55, 13'h0333, 13'h0666, 13'h0777, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("rsti_busy",   o_busy,      0);
        checkOutput("rsti_valid",  o_res_valid, 0);
        checkOutput("rsti_data",   o_res_data,  0);
        checkOutput("rsti_id",     o_res_id,    0);
        checkOutput("rsti_mulop1", o_mul_op_1,  0);
        checkOutput("rsti_ready",  o_req_ready, 0);
        nextDrive();
        i_reset_n = 1'b1;
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checkOutput("rsti_no_result", o_res_valid, 0);
            nextDrive();
        end
        applyStimulus(2'b11, 13'h0111, 13'h0222, 13'h0333, 13'h0444, 1'b1);
        @(negedge clock);
        checkOutput("rsti_next_grant", o_req_ready, 2'b01);
        nextDrive();
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        nextDrive();
        nextDrive();
        nextDrive();

        // Zero operand: bypass when enabled, normal path otherwise.
        doReset();
        applyStimulus(2'b01, 13'h0A55, 13'h0333, 13'h0000, 13'h0000, 1'b1);
        nextDrive();
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        nextDrive();
        nextDrive();
        applyStimulus(2'b10, 13'h0000, 13'h0000, 13'h1000, 13'h0C1D, 1'b0);
        @(negedge clock);
        checkOutput("zero_ready", o_req_ready, 2'b10);
        nextDrive();
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0);
        @(negedge clock);
`ifdef ARB_MULT_ZERO_BYPASS_EN
        checkOutput("byp_valid",  o_res_valid, 1);
        checkOutput("byp_data",   o_res_data,  13'h1000);
        checkOutput("byp_id",     o_res_id,    1);
        checkOutput("byp_mulop1", o_mul_op_1,  13'h0A55);
        checkOutput("byp_mulop2", o_mul_op_2,  13'h0333);
`else
        checkOutput("zero_issue_valid", o_res_valid, 0);
        checkOutput("zero_mulop1", o_mul_op_1, 13'h1000);
        checkOutput("zero_mulop2", o_mul_op_2, 13'h0C1D);
        nextDrive();
        @(negedge clock);
        checkOutput("zero_valid", o_res_valid, 1);
        checkOutput("zero_data",  o_res_data,  mul_model(13'h1000, 13'h0C1D));
        checkOutput("zero_id",    o_res_id,    1);
`endif
        nextDrive();
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        nextDrive();
        @(negedge clock);
        checkOutput("zero_idle_busy", o_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
